alu_pipe: RTL and testbench

- Parametrised, handshaked successor to the softcore's combinational ALU. Operand width is generic.
- Results are registered, with a valid/ready handshake on both input and output.
- Multiplication uses an iterative shift-add unit, so MUL and MULHU are multi-cycle and produce the full 2W-bit product.
- Adds signed/unsigned compares, saturating add/sub for NPU requantisation paths, and a full flag set.
- Sits between the softcore decode stage and writeback.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_pipe_mul_iter.sv | 57 +++++
 rtl/alu_pipe.sv | 185 ++++++++++++++++++
 tb/tb_alu_pipe.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcodes, FSM states and
// saturation bounds for the signed saturating add/subtract.
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_NOT   = 4'b0101;
    localparam logic [3:0] OP_SLL   = 4'b0110;
    localparam logic [3:0] OP_SRL   = 4'b0111;
    localparam logic [3:0] OP_SRA   = 4'b1000;
    localparam logic [3:0] OP_SLT   = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_SLTU  = 4'b1011;
    localparam logic [3:0] OP_MULHU = 4'b1100;
    localparam logic [3:0] OP_SADD  = 4'b1101;
    localparam logic [3:0] OP_SSUB  = 4'b1110;
    localparam logic [3:0] OP_RSVD  = 4'b1111;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    // Largest positive two's-complement value of the given width (0x7F..F).
    function automatic logic [63:0] sat_max(input int unsigned width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    // Most negative two's-complement value of the given width (0x80..0).
    function automatic logic [63:0] sat_min(input int unsigned width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/alu_pipe_mul_iter.sv
// Iterative shift-add unsigned multiplier producing the full 2W-bit product.
// One partial product is accumulated per clock; 'done' is high during the last
// step and 'product' then already includes that final step.
module mul_iter #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    logic [2*DATA_W-1:0] acc;
    logic [2*DATA_W-1:0] mcand;
    logic [DATA_W-1:0]   mplier;
    logic [CNT_W-1:0]    count;
    logic [2*DATA_W-1:0] acc_next;

    // Add the shifted multiplicand when the current multiplier bit is set.
    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

    assign busy    = (count != '0);
    assign done    = (count == CNT_W'(1));
    assign product = acc_next;

    // Load operands on start, then step once per cycle until the count expires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= {{DATA_W{1'b0}}, a};
            mplier <= b;
            count  <= CNT_W'(DATA_W);
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - 1'b1;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU between decode and writeback. Single-cycle ops register their
// result on the accepting edge; MUL/MULHU run through the iterative multiplier.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              neg,
    output logic              carry,
    output logic              ovf,
    output logic              illegal
);

    localparam int SH_W = $clog2(DATA_W);
    localparam logic [DATA_W-1:0] SAT_MAX = DATA_W'(sat_max(DATA_W));
    localparam logic [DATA_W-1:0] SAT_MIN = DATA_W'(sat_min(DATA_W));

    state_t state, state_next;

    logic                  accept;
    logic                  is_mul;
    logic                  mul_start;
    logic                  mul_busy;
    logic                  mul_done;
    logic                  mul_high_q;
    logic [2*DATA_W-1:0]   mul_product;
    logic [DATA_W-1:0]     mul_res;

    logic [DATA_W:0]       sum_ext;
    logic [DATA_W:0]       diff_ext;
    logic                  add_ovf;
    logic                  sub_ovf;
    logic [SH_W-1:0]       shamt;

    logic [DATA_W-1:0]     alu_res;
    logic                  alu_carry;
    logic                  alu_ovf;
    logic                  alu_illegal;

    assign is_mul    = (op == OP_MUL) || (op == OP_MULHU);
    assign in_ready  = (state == S_IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && is_mul;

    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};
    assign add_ovf  = (a[DATA_W-1] == b[DATA_W-1]) && (sum_ext[DATA_W-1] != a[DATA_W-1]);
    assign sub_ovf  = (a[DATA_W-1] != b[DATA_W-1]) && (diff_ext[DATA_W-1] != a[DATA_W-1]);
    assign shamt    = b[SH_W-1:0];
    assign mul_res  = mul_high_q ? mul_product[2*DATA_W-1:DATA_W] : mul_product[DATA_W-1:0];

    mul_iter #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // Single-cycle datapath: result plus the op-specific carry/overflow flags.
    always_comb begin
        alu_res     = '0;
        alu_carry   = 1'b0;
        alu_ovf     = 1'b0;
        alu_illegal = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res   = sum_ext[DATA_W-1:0];
                alu_carry = sum_ext[DATA_W];
                alu_ovf   = add_ovf;
            end
            OP_SUB: begin
                alu_res   = diff_ext[DATA_W-1:0];
                alu_carry = diff_ext[DATA_W];
                alu_ovf   = sub_ovf;
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOT:  alu_res = ~a;
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $signed(a) >>> shamt;
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (a < b)};
            OP_SADD: begin
                if (add_ovf) begin
                    alu_res = a[DATA_W-1] ? SAT_MIN : SAT_MAX;
                    alu_ovf = 1'b1;
                end else begin
                    alu_res = sum_ext[DATA_W-1:0];
                end
            end
            OP_SSUB: begin
                if (sub_ovf) begin
                    alu_res = a[DATA_W-1] ? SAT_MIN : SAT_MAX;
                    alu_ovf = 1'b1;
                end else begin
                    alu_res = diff_ext[DATA_W-1:0];
                end
            end
            OP_RSVD: alu_illegal = 1'b1;
            default: alu_res = '0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Enter BUSY when a multiply is accepted, leave on its final step.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (mul_start) state_next = S_BUSY;
            S_BUSY:  if (mul_done)  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output register: load on single-cycle accept or multiply completion, else retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            result     <= '0;
            zero       <= 1'b0;
            neg        <= 1'b0;
            carry      <= 1'b0;
            ovf        <= 1'b0;
            illegal    <= 1'b0;
            mul_high_q <= 1'b0;
        end else begin
            if (accept && !is_mul) begin
                out_valid <= 1'b1;
                result    <= alu_res;
                zero      <= (alu_res == '0);
                neg       <= alu_res[DATA_W-1];
                carry     <= alu_carry;
                ovf       <= alu_ovf;
                illegal   <= alu_illegal;
            end else if (mul_done) begin
                out_valid <= 1'b1;
                result    <= mul_res;
                zero      <= (mul_res == '0);
                neg       <= mul_res[DATA_W-1];
                carry     <= 1'b0;
                ovf       <= 1'b0;
                illegal   <= 1'b0;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (mul_start) begin
                mul_high_q <= (op == OP_MULHU);
            end
        end
    end

    // A multiply may only finish into an empty output register.
    mul_done_into_empty: assert property (@(posedge clk) disable iff (!rst_n) mul_done |-> !out_valid);

    // The multiplier's own busy indication must track the FSM.
    busy_matches_state: assert property (@(posedge clk) disable iff (!rst_n) (state == S_BUSY) == mul_busy);

endmodule

// File: tb/tb_alu_pipe.sv
// Testbench for alu_pipe: directed checks on a 32-bit instance, then a
// randomized sweep of an 8-bit instance against an arithmetic reference model.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int SWEEP_N      = 10000;
    localparam int SWEEP_BUDGET = 70000;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic        zero, neg, carry, ovf, illegal;
    logic [31:0] a, b, result;
    logic [3:0]  op;

    logic        s8_in_valid, s8_in_ready, s8_out_valid, s8_out_ready;
    logic        s8_zero, s8_neg, s8_carry, s8_ovf, s8_illegal;
    logic [7:0]  s8_a, s8_b, s8_result;
    logic [3:0]  s8_op;

    int compare_count = 0;
    int fail_count    = 0;

    int          lat, busy_bad, waited, hold_bad, issued, cycles;
    bit          acc, ret;
    logic [63:0] obs, expv;
    logic [63:0] exp_q[$];

    alu_pipe #(.DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .neg       (neg),
        .carry     (carry),
        .ovf       (ovf),
        .illegal   (illegal)
    );

    alu_pipe #(.DATA_W(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s8_in_valid),
        .in_ready  (s8_in_ready),
        .a         (s8_a),
        .b         (s8_b),
        .op        (s8_op),
        .out_valid (s8_out_valid),
        .out_ready (s8_out_ready),
        .result    (s8_result),
        .zero      (s8_zero),
        .neg       (s8_neg),
        .carry     (s8_carry),
        .ovf       (s8_ovf),
        .illegal   (s8_illegal)
    );

    // Reference: returns {illegal, ovf, carry, neg, zero} above a w-bit result.
    function automatic logic [63:0] model(input int w, input logic [3:0] op_i,
                                          input logic [63:0] av, input logic [63:0] bv);
        logic [63:0] mask, r, prod, flags;
        longint      sa, sb, s, smax, smin;
        int          sh;
        logic        c, v, ill, zf, nf;
        mask = (64'd1 << w) - 64'd1;
        smax = (longint'(1) << (w - 1)) - 1;
        smin = -(longint'(1) << (w - 1));
        sa   = (av >= (64'd1 << (w - 1))) ? longint'(av) - longint'(64'd1 << w) : longint'(av);
        sb   = (bv >= (64'd1 << (w - 1))) ? longint'(bv) - longint'(64'd1 << w) : longint'(bv);
        sh   = int'(bv % 64'(w));
        prod = av * bv;
        r = 64'd0; c = 1'b0; v = 1'b0; ill = 1'b0; s = 0;
        case (op_i)
            OP_ADD: begin
                r = (av + bv) & mask;
                c = ((av + bv) >> w) != 64'd0;
                s = sa + sb;
                v = (s > smax) || (s < smin);
            end
            OP_SUB: begin
                r = (av - bv) & mask;
                c = av < bv;
                s = sa - sb;
                v = (s > smax) || (s < smin);
            end
            OP_AND:   r = av & bv;
            OP_OR:    r = av | bv;
            OP_XOR:   r = av ^ bv;
            OP_NOT:   r = ~av & mask;
            OP_SLL:   r = (av << sh) & mask;
            OP_SRL:   r = av >> sh;
            OP_SRA:   r = 64'(sa >>> sh) & mask;
            OP_SLT:   r = (sa < sb) ? 64'd1 : 64'd0;
            OP_SLTU:  r = (av < bv) ? 64'd1 : 64'd0;
            OP_MUL:   r = prod & mask;
            OP_MULHU: r = prod >> w;
            OP_SADD, OP_SSUB: begin
                s = (op_i == OP_SADD) ? sa + sb : sa - sb;
                if (s > smax) begin
                    s = smax; v = 1'b1;
                end else if (s < smin) begin
                    s = smin; v = 1'b1;
                end
                r = 64'(s) & mask;
            end
            default: ill = 1'b1;
        endcase
        zf    = (r == 64'd0);
        nf    = r[w-1];
        flags = {59'd0, ill, v, c, nf, zf};
        return (flags << w) | r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compare_count++;
        assert (observed === expected)
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present an operation to the 32-bit instance and hold it until accepted.
    task automatic applyStimulus(input logic [3:0] op_i, input logic [31:0] a_i,
                                 input logic [31:0] b_i, output int waited_o);
        bit taken;
        taken    = 1'b0;
        waited_o = 0;
        op = op_i; a = a_i; b = b_i; in_valid = 1'b1;
        while (!taken && waited_o < 64) begin
            @(negedge clk);
            taken = in_ready;
            @(posedge clk); #1;
            if (!taken) waited_o++;
        end
        in_valid = 1'b0;
        checkOutput("accepted", 64'(taken), 64'd1);
    endtask

    // Count cycles until out_valid, noting any cycle where in_ready was high.
    task automatic waitResult(input int max_cycles, output int lat_o, output int busy_bad_o);
        lat_o = 0;
        busy_bad_o = 0;
        while (!out_valid && lat_o < max_cycles) begin
            if (in_ready !== 1'b0) busy_bad_o++;
            @(posedge clk); #1;
            lat_o++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
        s8_in_valid = 1'b0; s8_out_ready = 1'b0; s8_a = '0; s8_b = '0; s8_op = '0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset.result", 64'(result), 64'd0);
        checkOutput("reset.flags", 64'({illegal, ovf, carry, neg, zero}), 64'd0);
        checkOutput("reset.in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;

        applyStimulus(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, waited);
        waitResult(4, lat, busy_bad);
        checkOutput("add.latency", 64'(lat), 64'd0);
        checkOutput("add.result", 64'(result), 64'h8000_0000);
        checkOutput("add.flags", 64'({illegal, ovf, carry, neg, zero}), 64'b01010);

        applyStimulus(OP_SADD, 32'h7FFF_FFF0, 32'h0000_0020, waited);
        checkOutput("sadd.result", 64'(result), 64'h7FFF_FFFF);
        checkOutput("sadd.flags", 64'({illegal, ovf, carry, neg, zero}), 64'b01000);

        applyStimulus(OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, waited);
        checkOutput("slt.result", 64'(result), 64'd1);
        checkOutput("slt.flags", 64'({illegal, ovf, carry, neg, zero}), 64'b00000);

        applyStimulus(OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, waited);
        checkOutput("sltu.result", 64'(result), 64'd0);
        checkOutput("sltu.flags", 64'({illegal, ovf, carry, neg, zero}), 64'b00001);

        applyStimulus(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, waited);
        waitResult(100, lat, busy_bad);
        checkOutput("mulhu.latency", 64'(lat), 64'd32);
        checkOutput("mulhu.in_ready_low", 64'(busy_bad), 64'd0);
        checkOutput("mulhu.result", 64'(result), 64'hFFFF_FFFE);
        checkOutput("mulhu.flags", 64'({illegal, ovf, carry, neg, zero}), 64'b00010);

        applyStimulus(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, waited);
        waitResult(100, lat, busy_bad);
        checkOutput("mul.latency", 64'(lat), 64'd32);
        checkOutput("mul.in_ready_low", 64'(busy_bad), 64'd0);
        checkOutput("mul.result", 64'(result), 64'h0000_0001);
        checkOutput("mul.flags", 64'({illegal, ovf, carry, neg, zero}), 64'b00000);

        applyStimulus(OP_RSVD, 32'h1234_5678, 32'h0000_0042, waited);
        checkOutput("rsvd.result", 64'(result), 64'd0);
        checkOutput("rsvd.flags", 64'({illegal, ovf, carry, neg, zero}), 64'b10001);

        // Backpressure: drain, then stall an AND result for five cycles.
        @(posedge clk); #1;
        out_ready = 1'b0;
        applyStimulus(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, waited);
        hold_bad = 0;
        repeat (5) begin
            if (out_valid !== 1'b1 || result !== 32'hF000_F000 || in_ready !== 1'b0 ||
                {illegal, ovf, carry, neg, zero} !== 5'b00010) hold_bad++;
            @(posedge clk); #1;
        end
        checkOutput("bp.hold_stable", 64'(hold_bad), 64'd0);
        out_ready = 1'b1;
        applyStimulus(OP_XOR, 32'hA5A5_A5A5, 32'h5A5A_5A5A, waited);
        checkOutput("bp.same_edge", 64'(waited), 64'd0);
        checkOutput("bp.out_valid", 64'(out_valid), 64'd1);
        checkOutput("bp.xor_result", 64'(result), 64'hFFFF_FFFF);

        // Reset during the tenth cycle of a multiply.
        applyStimulus(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0, waited);
        repeat (9) begin
            @(posedge clk); #1;
        end
        checkOutput("rst_mid_mul.busy", 64'(in_ready), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_mul.out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_mid_mul.result", 64'(result), 64'd0);
        checkOutput("rst_mid_mul.flags", 64'({illegal, ovf, carry, neg, zero}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_mid_mul.in_ready", 64'(in_ready), 64'd1);
        hold_bad = 0;
        repeat (40) begin
            if (out_valid !== 1'b0) hold_bad++;
            @(posedge clk); #1;
        end
        checkOutput("rst_mid_mul.no_result", 64'(hold_bad), 64'd0);

        // Randomized sweep of the 8-bit instance with random backpressure.
        issued = 0;
        cycles = 0;
        while ((issued < SWEEP_N || exp_q.size() != 0) && cycles < SWEEP_BUDGET) begin
            if (!s8_in_valid && issued < SWEEP_N && $urandom_range(7) != 0) begin
                s8_in_valid = 1'b1;
                if (issued == 0) begin
                    s8_op = OP_SRA; s8_a = 8'h80; s8_b = 8'd7;
                end else if (issued == 1) begin
                    s8_op = OP_RSVD; s8_a = 8'($urandom); s8_b = 8'($urandom);
                end else begin
                    s8_op = 4'($urandom); s8_a = 8'($urandom); s8_b = 8'($urandom);
                end
            end
            s8_out_ready = ($urandom_range(3) != 0);
            @(negedge clk);
            acc = s8_in_valid && s8_in_ready;
            ret = s8_out_valid && s8_out_ready;
            obs = {51'd0, s8_illegal, s8_ovf, s8_carry, s8_neg, s8_zero, s8_result};
            @(posedge clk); #1;
            cycles++;
            if (ret) begin
                if (exp_q.size() != 0) begin
                    expv = exp_q.pop_front();
                    checkOutput("sweep.txn", obs, expv);
                end else begin
                    checkOutput("sweep.spurious_out_valid", 64'(ret), 64'd0);
                end
            end
            if (acc) begin
                exp_q.push_back(model(8, s8_op, 64'(s8_a), 64'(s8_b)));
                issued++;
                s8_in_valid = 1'b0;
            end
        end
        checkOutput("sweep.issued", 64'(issued), 64'(SWEEP_N));
        checkOutput("sweep.drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule
